// File: rtl/noc_ejector.sv
// NoC ejection port: parses HEADER/SIZE/PAYLOAD packets and buffers flits toward a sink.
// Optional macro NOC_EJECTOR_HEADER_DROP_EN: header flits are parsed but not written to the FIFO.
module noc_ejector #(
  parameter int unsigned FLIT_SIZE        = 32,
  parameter int unsigned BUFFER_SIZE      = 8,
  parameter int unsigned MAX_PAYLOAD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 noc_rx_i,
  output logic                 noc_credit_o,
  input  logic [FLIT_SIZE-1:0] noc_data_i,
  output logic                 snk_tx_o,
  input  logic                 snk_credit_i,
  output logic [FLIT_SIZE-1:0] snk_data_o,
  output logic                 pkt_done_o,
  output logic                 size_err_o
);

  localparam int unsigned ADDR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_SIZE    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];

  logic                 noc_xfer_c;
  logic                 snk_xfer_c;
  logic                 wr_en_c;
  logic                 rd_en_c;

  // Handshakes are qualified by registered full/empty, so a same-cycle read never frees a credit.
  assign noc_credit_o = ~full_q;
  assign snk_tx_o     = ~empty_q;
  assign noc_xfer_c   = noc_rx_i & ~full_q;
  assign snk_xfer_c   = snk_credit_i & ~empty_q;
  assign rd_en_c      = snk_xfer_c;

`ifdef NOC_EJECTOR_HEADER_DROP_EN
  assign wr_en_c = noc_xfer_c & (state_q != ST_HEADER);
`else
  assign wr_en_c = noc_xfer_c;
`endif

  // Head entry is forced to zero while empty so the sink bus is quiet after reset.
  assign snk_data_o = empty_q ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign pkt_done_o = done_q;
  assign size_err_o = err_q;

  // FIFO pointer and flag next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
              (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
  end

  // Packet parser next-state; advances only on NoC transfers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (noc_xfer_c) begin
      unique case (state_q)
        ST_HEADER: begin
          state_d = ST_SIZE;
        end
        ST_SIZE: begin
          cnt_d = noc_data_i;
          if (noc_data_i > FLIT_SIZE'(MAX_PAYLOAD_SIZE)) err_d = 1'b1;
          if (noc_data_i == '0) begin
            state_d = ST_HEADER;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          cnt_d = cnt_q - FLIT_SIZE'(1);
          if (cnt_q == FLIT_SIZE'(1)) begin
            state_d = ST_HEADER;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_HEADER;
        end
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_HEADER;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= noc_data_i;
  end

`ifndef SYNTHESIS
  a_flags_exclusive: assert property (@(posedge clk_i) disable iff (rst_i) !(full_q && empty_q));
`endif

endmodule

// File: tb/tb_noc_ejector.sv
// Directed self-checking bench for noc_ejector (default parameters).
// Build with NOC_EJECTOR_HEADER_DROP_EN to run the header-drop scenario instead.
module tb_noc_ejector;

  logic        clk_i;
  logic        rst_i;
  logic        noc_rx_i;
  logic        noc_credit_o;
  logic [31:0] noc_data_i;
  logic        snk_tx_o;
  logic        snk_credit_i;
  logic [31:0] snk_data_o;
  logic        pkt_done_o;
  logic        size_err_o;

  int checks;
  int failures;

  noc_ejector #(
    .FLIT_SIZE(32),
    .BUFFER_SIZE(8),
    .MAX_PAYLOAD_SIZE(32)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .noc_rx_i(noc_rx_i),
    .noc_credit_o(noc_credit_o),
    .noc_data_i(noc_data_i),
    .snk_tx_o(snk_tx_o),
    .snk_credit_i(snk_credit_i),
    .snk_data_o(snk_data_o),
    .pkt_done_o(pkt_done_o),
    .size_err_o(size_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one edge; outputs are then sampled and inputs driven 1 time unit after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    noc_rx_i   = v;
    noc_data_i = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 32'h0);
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    snk_credit_i = 1'b0;
    do_reset();
    checks++;
    if (noc_credit_o !== 1'b1) begin
      failures++; $display("FAIL reset_credit got=%b exp=1", noc_credit_o);
    end
    checks++;
    if (snk_tx_o !== 1'b0) begin
      failures++; $display("FAIL reset_tx got=%b exp=0", snk_tx_o);
    end
    checks++;
    if (snk_data_o !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", snk_data_o);
    end
    checks++;
    if (pkt_done_o !== 1'b0 || size_err_o !== 1'b0) begin
      failures++; $display("FAIL reset_status got=%b%b exp=00", pkt_done_o, size_err_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] f [5];
    f[0] = 32'h0000_0102; f[1] = 32'd3;
    f[2] = 32'hAAAA_0001; f[3] = 32'hBBBB_0002; f[4] = 32'hCCCC_0003;
    do_reset();
    snk_credit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, f[i]);
      step();
      checks++;
      if (snk_tx_o !== 1'b1 || snk_data_o !== f[i]) begin
        failures++; $display("FAIL basic_flit%0d got=%b/%h exp=1/%h", i, snk_tx_o, snk_data_o, f[i]);
      end
      checks++;
      if (pkt_done_o !== (i == 4)) begin
        failures++; $display("FAIL basic_done%0d got=%b exp=%b", i, pkt_done_o, (i == 4));
      end
    end
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (snk_tx_o !== 1'b0 || pkt_done_o !== 1'b0) begin
      failures++; $display("FAIL basic_idle got=%b%b exp=00", snk_tx_o, pkt_done_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] f [10];
    int k;
    int got;
    int mism;
    logic acc;
    f[0] = 32'h20; f[1] = 32'd8;
    for (int j = 0; j < 8; j++) f[j+2] = 32'h300 + 32'(j);
    do_reset();
    snk_credit_i = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      drive(k < 10, (k < 10) ? f[k] : 32'h0);
      acc = noc_credit_o && noc_rx_i;
      step();
      if (acc) k++;
    end
    checks++;
    if (k != 8) begin
      failures++; $display("FAIL bp_accepts got=%0d exp=8", k);
    end
    checks++;
    if (noc_credit_o !== 1'b0) begin
      failures++; $display("FAIL bp_credit_full got=%b exp=0", noc_credit_o);
    end
    checks++;
    if (snk_tx_o !== 1'b1 || snk_data_o !== f[0]) begin
      failures++; $display("FAIL bp_head_stable got=%b/%h exp=1/%h", snk_tx_o, snk_data_o, f[0]);
    end
    snk_credit_i = 1'b1;
    got  = 0;
    mism = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      drive(k < 10, (k < 10) ? f[k] : 32'h0);
      acc = noc_credit_o && noc_rx_i;
      if (snk_tx_o) begin
        if (snk_data_o !== f[got]) mism++;
        got++;
      end
      step();
      if (acc) k++;
    end
    drive(1'b0, 32'h0);
    checks++;
    if (got != 10 || mism != 0) begin
      failures++; $display("FAIL bp_drain got=%0d/%0d exp=10/0 (delivered/wrong)", got, mism);
    end
    checks++;
    if (snk_tx_o !== 1'b0) begin
      failures++; $display("FAIL bp_empty got=%b exp=0", snk_tx_o);
    end
  endtask

  task automatic test_zero_size();
    logic [31:0] f [5];
    f[0] = 32'h0A; f[1] = 32'd0; f[2] = 32'h0B; f[3] = 32'd1; f[4] = 32'h77;
    do_reset();
    snk_credit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, f[i]);
      step();
      checks++;
      if (snk_tx_o !== 1'b1 || snk_data_o !== f[i] || pkt_done_o !== (i == 1 || i == 4)) begin
        failures++; $display("FAIL zero_flit%0d got=%b/%h/%b exp=1/%h/%b", i, snk_tx_o,
                             snk_data_o, pkt_done_o, f[i], (i == 1 || i == 4));
      end
    end
    drive(1'b0, 32'h0);
    step();
  endtask

  task automatic test_size_err();
    logic [31:0] f [42];
    int n;
    int mism;
    int dones;
    int done_at;
    f[0] = 32'h0C; f[1] = 32'd40;
    for (int j = 0; j < 40; j++) f[j+2] = 32'h1000 + 32'(j);
    do_reset();
    snk_credit_i = 1'b1;
    n = 0; mism = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 42; i++) begin
      drive(1'b1, f[i]);
      step();
      if (snk_tx_o) begin
        if (snk_data_o !== f[i]) mism++;
        n++;
      end
      if (pkt_done_o) begin
        dones++; done_at = i;
      end
      if (i == 0) begin
        checks++;
        if (size_err_o !== 1'b0) begin
          failures++; $display("FAIL err_before_size got=%b exp=0", size_err_o);
        end
      end
      if (i == 1) begin
        checks++;
        if (size_err_o !== 1'b1) begin
          failures++; $display("FAIL err_set got=%b exp=1", size_err_o);
        end
      end
    end
    drive(1'b0, 32'h0);
    step();
    step();
    checks++;
    if (n != 42 || mism != 0) begin
      failures++; $display("FAIL err_forwarded got=%0d/%0d exp=42/0 (flits/wrong)", n, mism);
    end
    checks++;
    if (dones != 1 || done_at != 41) begin
      failures++; $display("FAIL err_done got=%0d@%0d exp=1@41", dones, done_at);
    end
    checks++;
    if (size_err_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", size_err_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] f [3];
    f[0] = 32'h0D; f[1] = 32'd1; f[2] = 32'h55;
    do_reset();
    snk_credit_i = 1'b0;
    drive(1'b1, 32'h0E); step();
    drive(1'b1, 32'd5);  step();
    drive(1'b1, 32'h91); step();
    drive(1'b1, 32'h92); step();
    rst_i = 1'b1;
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (snk_tx_o !== 1'b0 || snk_data_o !== 32'h0 || noc_credit_o !== 1'b1) begin
      failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/1", snk_tx_o, snk_data_o, noc_credit_o);
    end
    rst_i = 1'b0;
    snk_credit_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, f[i]);
      step();
      checks++;
      if (snk_tx_o !== 1'b1 || snk_data_o !== f[i] || pkt_done_o !== (i == 2)) begin
        failures++; $display("FAIL mid_flit%0d got=%b/%h/%b exp=1/%h/%b", i, snk_tx_o,
                             snk_data_o, pkt_done_o, f[i], (i == 2));
      end
    end
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (snk_tx_o !== 1'b0) begin
      failures++; $display("FAIL mid_empty got=%b exp=0", snk_tx_o);
    end
  endtask

  task automatic test_header_drop();
    logic [31:0] f [5];
    f[0] = 32'h0000_0102; f[1] = 32'd3;
    f[2] = 32'hAAAA_0001; f[3] = 32'hBBBB_0002; f[4] = 32'hCCCC_0003;
    do_reset();
    snk_credit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, f[i]);
      step();
      checks++;
      if (i == 0) begin
        if (snk_tx_o !== 1'b0) begin
          failures++; $display("FAIL drop_header got=%b exp=0", snk_tx_o);
        end
      end else if (snk_tx_o !== 1'b1 || snk_data_o !== f[i] || pkt_done_o !== (i == 4)) begin
        failures++; $display("FAIL drop_flit%0d got=%b/%h/%b exp=1/%h/%b", i, snk_tx_o,
                             snk_data_o, pkt_done_o, f[i], (i == 4));
      end
    end
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (snk_tx_o !== 1'b0) begin
      failures++; $display("FAIL drop_idle got=%b exp=0", snk_tx_o);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_i        = 1'b1;
    noc_rx_i     = 1'b0;
    noc_data_i   = 32'h0;
    snk_credit_i = 1'b0;
    test_reset();
`ifdef NOC_EJECTOR_HEADER_DROP_EN
    test_header_drop();
`else
    test_basic();
    test_backpressure();
    test_zero_size();
    test_size_err();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
